// File: rtl/loop_sequencer.sv
// Loop iteration sequencer.
// Takes a trip count and a direction on a start pulse and then presents one
// index per accepted valid/ready handshake, counting up (0 .. trip-1) or
// down (trip-1 .. 0). The final index is flagged with last, and a one-cycle
// done pulse follows completion. A trip of zero skips straight to done.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; no index presented
//   S_RUN  | index presented on idx/idx_valid, advancing on each transfer
//   S_DONE | single-cycle completion; done pulses, start is ignored
module loop_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] trip,
   input  logic             dir,
   input  logic             abort,
   output logic [WIDTH-1:0] idx,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic             last,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] idx_q;
   logic [WIDTH-1:0] trip_q;
   logic             dir_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] idx_d;
   logic [WIDTH-1:0] first_d;
   logic             at_term;
   logic             xfer;

   // Terminal compare on the latched loop, next index and the starting index
   // derived from the live start inputs.
   always_comb begin
      term    = trip_q - WIDTH'(1);
      at_term = dir_q ? (idx_q == '0) : (idx_q == term);
      idx_d   = dir_q ? (idx_q - WIDTH'(1)) : (idx_q + WIDTH'(1));
      first_d = dir ? (trip - WIDTH'(1)) : '0;
      xfer    = valid_q & idx_ready;
   end

   // Sequencer FSM with registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         trip_q  <= '0;
         dir_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  busy_q <= 1'b1;
                  if (trip != '0) begin
                     trip_q  <= trip;
                     dir_q   <= dir;
                     idx_q   <= first_d;
                     valid_q <= 1'b1;
                     state_q <= S_RUN;
                  end else begin
                     // empty loop: report completion without any index
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  // a transfer in this cycle still lands downstream, but the
                  // loop is abandoned without a done pulse
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (xfer) begin
                  if (at_term) begin
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign idx       = idx_q;
   assign idx_valid = valid_q;
   assign last      = valid_q & at_term;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: directed scenarios followed by random traffic.
// The driver expands each accepted start into the full expected index list;
// a negedge monitor compares the presented index against the queue head.
module tb_loop_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] trip;
   logic       dir;
   logic       abort;
   logic [7:0] idx;
   logic       idx_valid;
   logic       idx_ready;
   logic       last;
   logic       busy;
   logic       done;

   loop_sequencer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .trip      (trip),
      .dir       (dir),
      .abort     (abort),
      .idx       (idx),
      .idx_valid (idx_valid),
      .idx_ready (idx_ready),
      .last      (last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_at  = -1;
   int push_cyc = -1;
   bit abort_pend = 1'b0;
   logic [8:0] exp_q[$];   // {last, idx}

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected behaviour: index list for an accepted loop.
   task automatic push_loop(input int n, input bit d);
      for (int i = 0; i < n; i++) begin
         int v;
         v = d ? (n - 1 - i) : i;
         exp_q.push_back({(i == n - 1), 8'(v)});
      end
      push_cyc = cyc;
   endtask

   task automatic drive_cycle(input bit st, input logic [7:0] tr, input bit dr,
                              input bit ab, input bit rdy);
      bit idle;
      @(posedge clk);
      #2;
      if (abort_pend) begin
         exp_q.delete();
         done_at    = -1;
         abort_pend = 1'b0;
      end
      idle = rst_n && (exp_q.size() == 0) && (cyc != done_at);
      start     = st;
      trip      = tr;
      dir       = dr;
      abort     = ab;
      idx_ready = rdy;
      if (st && idle) begin
         if (tr == 8'd0) done_at = cyc + 1;
         else push_loop(int'(tr), dr);
      end else if (ab && exp_q.size() > 0) begin
         abort_pend = 1'b1;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      bit active;
      logic [8:0] f;
      active = (exp_q.size() > 0) && (cyc != push_cyc);
      chk(idx_valid == active, "idx_valid", int'(idx_valid), int'(active));
      if (idx_valid && exp_q.size() > 0) begin
         f = exp_q[0];
         chk(idx == f[7:0], "idx", int'(idx), int'(f[7:0]));
         chk(last == f[8], "last", int'(last), int'(f[8]));
         if (idx_ready) begin
            if (f[8]) done_at = cyc + 1;
            void'(exp_q.pop_front());
         end
      end
      chk(done == (cyc == done_at), "done", int'(done), int'(cyc == done_at));
      chk(busy == (active || cyc == done_at), "busy", int'(busy),
          int'(active || cyc == done_at));
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; trip = 8'd0; dir = 1'b0; abort = 1'b0; idx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk(idx == 8'd0, "reset_idx", int'(idx), 0);
      chk(idx_valid == 1'b0, "reset_valid", int'(idx_valid), 0);
      chk(last == 1'b0, "reset_last", int'(last), 0);
      chk(busy == 1'b0, "reset_busy", int'(busy), 0);
      chk(done == 1'b0, "reset_done", int'(done), 0);
      #2 rst_n = 1'b1;

      // trip 4 up, always ready
      drive_cycle(1'b1, 8'd4, 1'b0, 1'b0, 1'b1);
      idle_cycles(7);

      // trip 3 down with stalls
      drive_cycle(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
      drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      idle_cycles(4);

      // empty loop, then single-iteration down loop
      drive_cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
      idle_cycles(4);
      drive_cycle(1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
      idle_cycles(4);

      // longest up loop: no wrap past 254
      drive_cycle(1'b1, 8'd255, 1'b0, 1'b0, 1'b1);
      idle_cycles(262);

      // abort just after idx 5 is accepted, then a clean trip-2 loop
      drive_cycle(1'b1, 8'd10, 1'b0, 1'b0, 1'b1);
      idle_cycles(6);
      drive_cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
      idle_cycles(3);
      drive_cycle(1'b1, 8'd2, 1'b0, 1'b0, 1'b1);
      idle_cycles(5);

      // second start mid-run is ignored; also abort+start in IDLE
      drive_cycle(1'b1, 8'd10, 1'b0, 1'b0, 1'b1);
      idle_cycles(3);
      drive_cycle(1'b1, 8'd3, 1'b1, 1'b0, 1'b1);
      idle_cycles(12);
      drive_cycle(1'b1, 8'd2, 1'b1, 1'b1, 1'b1);
      idle_cycles(5);

      // asynchronous reset while idx 7 is presented
      drive_cycle(1'b1, 8'd10, 1'b0, 1'b0, 1'b1);
      idle_cycles(8);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      done_at = -1;
      #1;
      chk(idx == 8'd0, "async_rst_idx", int'(idx), 0);
      chk(idx_valid == 1'b0, "async_rst_valid", int'(idx_valid), 0);
      chk(last == 1'b0, "async_rst_last", int'(last), 0);
      chk(busy == 1'b0, "async_rst_busy", int'(busy), 0);
      chk(done == 1'b0, "async_rst_done", int'(done), 0);
      idle_cycles(2);
      @(posedge clk);
      #3 rst_n = 1'b1;
      drive_cycle(1'b1, 8'd2, 1'b0, 1'b0, 1'b1);
      idle_cycles(5);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bit st, dr, ab, rdy;
         logic [7:0] tr;
         st  = ($urandom_range(0, 3) == 0);
         dr  = $urandom_range(0, 1) != 0;
         ab  = ($urandom_range(0, 29) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         tr  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
         drive_cycle(st, tr, dr, ab, rdy);
      end

      // drain with a bounded budget
      for (int i = 0; i < 400 && (exp_q.size() > 0 || done_at >= cyc || abort_pend); i++)
         drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      idle_cycles(3);
      chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
